// File: rtl/datapath_seq_pkg.sv
// Shared types and helpers for the datapath fill sequencer: FSM state encoding,
// the ADD opcode used for seeding, and the run-length clamp.
package datapath_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SEED0 = 3'd2,
        ST_SEED1 = 3'd3,
        ST_RECUR = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_e;

    localparam logic [3:0]  OPCODE_ADD = 4'd1;
    localparam int unsigned MIN_LENGTH = 32'd2;

    // A run always writes both seeds and can never exceed the register file.
    function automatic int unsigned clamp_length(input int unsigned length,
                                                 input int unsigned max_length);
        int unsigned result;
        if (length < MIN_LENGTH) begin
            result = MIN_LENGTH;
        end else if (length > max_length) begin
            result = max_length;
        end else begin
            result = length;
        end
        return result;
    endfunction

endpackage

// File: rtl/datapath_seq_ctrl_onehot_decoder.sv
// Binary index to one-hot enable; out-of-range indices produce no enable.
module onehot_decoder #(
    parameter int WIDTH     = 16,
    parameter int SEL_WIDTH = $clog2(WIDTH)
) (
    input  logic [SEL_WIDTH-1:0] i_index,
    input  logic                 i_enable,
    output logic [WIDTH-1:0]     o_onehot
);

    // Decode the selected index when enabled.
    always_comb begin
        o_onehot = '0;
        if (i_enable && (int'(i_index) < WIDTH)) begin
            o_onehot[i_index] = 1'b1;
        end else begin
            o_onehot = '0;
        end
    end

endmodule

// File: rtl/datapath_seq_ctrl.sv
// Sequencer filling datapath registers with r(i) = r(i-2) OP r(i-1) from two seeds.
// Optional single-step gating (I_STEP) is enabled with DATAPATH_SEQ_STEP_EN.
module datapath_seq_ctrl
    import datapath_seq_pkg::*;
#(
    parameter int REG_COUNT  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = $clog2(REG_COUNT)
) (
    input  logic                  I_CLK,
    input  logic                  I_NRESET,
    input  logic                  I_START,
    input  logic                  I_LOOP,
`ifdef DATAPATH_SEQ_STEP_EN
    input  logic                  I_STEP,
`endif
    input  logic [SEL_WIDTH:0]    I_LENGTH,
    input  logic [DATA_WIDTH-1:0] I_SEED_0,
    input  logic [DATA_WIDTH-1:0] I_SEED_1,
    input  logic [3:0]            I_OPCODE,
    output logic [REG_COUNT-1:0]  O_REG_WRITE_ENABLE,
    output logic [SEL_WIDTH-1:0]  O_REG_A_SELECT,
    output logic [SEL_WIDTH-1:0]  O_REG_B_SELECT,
    output logic [DATA_WIDTH-1:0] O_IMMEDIATE,
    output logic                  O_IMMEDIATE_SELECT,
    output logic [3:0]            O_OPCODE,
    output logic                  O_DATAPATH_NRESET,
    output logic                  O_BUSY,
    output logic                  O_DONE,
    output logic [SEL_WIDTH-1:0]  O_STEP_INDEX
);

    localparam int LEN_WIDTH = SEL_WIDTH + 1;

    seq_state_e            state_q, state_d;
    logic [SEL_WIDTH-1:0]  step_q, step_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [DATA_WIDTH-1:0] seed0_q, seed0_d;
    logic [DATA_WIDTH-1:0] seed1_q, seed1_d;
    logic [3:0]            opcode_q, opcode_d;

    logic                  load_s;
    logic                  last_step_s;
    logic                  step_ok_s;
    logic                  wr_en_s;
    logic [LEN_WIDTH-1:0]  len_clamped_s;

`ifdef DATAPATH_SEQ_STEP_EN
    assign step_ok_s = I_STEP;
`else
    assign step_ok_s = 1'b1;
`endif

    assign len_clamped_s = LEN_WIDTH'(clamp_length(32'(I_LENGTH), REG_COUNT));
    assign last_step_s   = ({1'b0, step_q} == (len_q - LEN_WIDTH'(1)));

    // Next-state, step counter and input-latch control.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_START) begin
                    load_s  = 1'b1;
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
                step_d = '0;
            end
            ST_CLEAR: begin
                state_d = ST_SEED0;
                step_d  = '0;
            end
            ST_SEED0: begin
                if (step_ok_s) begin
                    state_d = ST_SEED1;
                    step_d  = SEL_WIDTH'(1);
                end else begin
                    state_d = ST_SEED0;
                end
            end
            ST_SEED1: begin
                if (!step_ok_s) begin
                    state_d = ST_SEED1;
                end else if (len_q == LEN_WIDTH'(2)) begin
                    state_d = ST_DONE;
                    step_d  = '0;
                end else begin
                    state_d = ST_RECUR;
                    step_d  = SEL_WIDTH'(2);
                end
            end
            ST_RECUR: begin
                if (!step_ok_s) begin
                    state_d = ST_RECUR;
                end else if (last_step_s) begin
                    state_d = ST_DONE;
                    step_d  = '0;
                end else begin
                    step_d  = step_q + SEL_WIDTH'(1);
                end
            end
            ST_DONE: begin
                if (I_LOOP) begin
                    load_s  = 1'b1;
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
                step_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Run parameters are captured once so mid-run input changes are harmless.
    always_comb begin
        if (load_s) begin
            len_d    = len_clamped_s;
            seed0_d  = I_SEED_0;
            seed1_d  = I_SEED_1;
            opcode_d = I_OPCODE;
        end else begin
            len_d    = len_q;
            seed0_d  = seed0_q;
            seed1_d  = seed1_q;
            opcode_d = opcode_q;
        end
    end

    // State and latched run parameters.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            len_q    <= LEN_WIDTH'(2);
            seed0_q  <= '0;
            seed1_q  <= '0;
            opcode_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            len_q    <= len_d;
            seed0_q  <= seed0_d;
            seed1_q  <= seed1_d;
            opcode_q <= opcode_d;
        end
    end

    // Moore output decode from state and step counter.
    always_comb begin
        wr_en_s            = 1'b0;
        O_REG_A_SELECT     = '0;
        O_REG_B_SELECT     = '0;
        O_IMMEDIATE        = '0;
        O_IMMEDIATE_SELECT = 1'b0;
        O_OPCODE           = 4'd0;
        O_DATAPATH_NRESET  = 1'b1;
        O_BUSY             = 1'b0;
        O_DONE             = 1'b0;
        O_STEP_INDEX       = '0;
        case (state_q)
            ST_IDLE: begin
                O_BUSY = 1'b0;
            end
            ST_CLEAR: begin
                O_DATAPATH_NRESET = 1'b0;
                O_BUSY            = 1'b1;
            end
            ST_SEED0, ST_SEED1: begin
                // Register is zero after CLEAR, so A + imm loads the seed.
                wr_en_s            = step_ok_s;
                O_REG_A_SELECT     = step_q;
                O_IMMEDIATE        = (state_q == ST_SEED0) ? seed0_q : seed1_q;
                O_IMMEDIATE_SELECT = 1'b1;
                O_OPCODE           = OPCODE_ADD;
                O_BUSY             = 1'b1;
                O_STEP_INDEX       = step_q;
            end
            ST_RECUR: begin
                wr_en_s        = step_ok_s;
                O_REG_A_SELECT = step_q - SEL_WIDTH'(2);
                O_REG_B_SELECT = step_q - SEL_WIDTH'(1);
                O_OPCODE       = opcode_q;
                O_BUSY         = 1'b1;
                O_STEP_INDEX   = step_q;
            end
            ST_DONE: begin
                O_DONE = 1'b1;
            end
            default: begin
                O_BUSY = 1'b0;
            end
        endcase
    end

    onehot_decoder #(
        .WIDTH     (REG_COUNT),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_we_dec (
        .i_index  (step_q),
        .i_enable (wr_en_s),
        .o_onehot (O_REG_WRITE_ENABLE)
    );

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Self-checking bench for datapath_seq_ctrl with a small behavioural datapath.
module tb_datapath_seq_ctrl;

    typedef struct packed {
        logic [15:0] we;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [15:0] imm;
        logic        isel;
        logic [3:0]  op;
        logic        dpn;
        logic        busy;
        logic        done;
        logic [3:0]  st;
    } out_t;

    typedef struct {
        logic        start;
        logic        loop;
        logic [4:0]  len;
        logic [15:0] s0;
        logic [15:0] s1;
        logic [3:0]  op;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, loop, step;
    logic [4:0]  length;
    logic [15:0] seed0, seed1;
    logic [3:0]  opcode;
    logic [15:0] o_we;
    logic [3:0]  o_a, o_b, o_op, o_st;
    logic [15:0] o_imm;
    logic        o_isel, o_dpn, o_busy, o_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] regs [16];
    logic [15:0] wr_val [256];
    int          wr_cnt = 0;
    logic [15:0] dp_a_s, dp_b_s, dp_res_s;

    always #5 clk = ~clk;

    datapath_seq_ctrl dut (
        .I_CLK              (clk),
        .I_NRESET           (rst_n),
        .I_START            (start),
        .I_LOOP             (loop),
`ifdef DATAPATH_SEQ_STEP_EN
        .I_STEP             (step),
`endif
        .I_LENGTH           (length),
        .I_SEED_0           (seed0),
        .I_SEED_1           (seed1),
        .I_OPCODE           (opcode),
        .O_REG_WRITE_ENABLE (o_we),
        .O_REG_A_SELECT     (o_a),
        .O_REG_B_SELECT     (o_b),
        .O_IMMEDIATE        (o_imm),
        .O_IMMEDIATE_SELECT (o_isel),
        .O_OPCODE           (o_op),
        .O_DATAPATH_NRESET  (o_dpn),
        .O_BUSY             (o_busy),
        .O_DONE             (o_done),
        .O_STEP_INDEX       (o_st)
    );

    // Behavioural datapath: combinational read, ADD only, clear on low nreset.
    always_comb begin
        dp_a_s   = regs[o_a];
        dp_b_s   = o_isel ? o_imm : regs[o_b];
        dp_res_s = (o_op == 4'd1) ? (dp_a_s + dp_b_s) : 16'h0000;
    end

    always @(posedge clk) begin
        if (!rst_n || !o_dpn) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (o_we[i]) begin
                    regs[i] <= dp_res_s;
                    if (wr_cnt < 256) wr_val[wr_cnt] <= dp_res_s;
                    wr_cnt <= wr_cnt + 1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic out_t mk(input logic [15:0] we, input logic [3:0] a, input logic [3:0] b,
                                input logic [15:0] imm, input logic isel, input logic [3:0] op,
                                input logic dpn, input logic busy, input logic done,
                                input logic [3:0] st);
        out_t o;
        o.we = we; o.a = a; o.b = b; o.imm = imm; o.isel = isel; o.op = op;
        o.dpn = dpn; o.busy = busy; o.done = done; o.st = st;
        return o;
    endfunction

    function automatic out_t sample_out();
        return mk(o_we, o_a, o_b, o_imm, o_isel, o_op, o_dpn, o_busy, o_done, o_st);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and count edges after E0 until O_DONE (bounded).
    task automatic run_until_done(input logic [4:0] len, input logic [15:0] s0, input logic [15:0] s1,
                                  input logic lp, output int n);
        length = len; seed0 = s0; seed1 = s1; opcode = 4'd1; loop = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!o_done && n < 64) begin
            tick();
            n++;
        end
    endtask

    vec_t vecs [11];
    out_t idle_o;
    int   fib [16];
    int   loop_exp [8];
    int   n, base;
    logic found;

    initial begin
        idle_o   = mk(16'h0, 4'h0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        fib      = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987};
        loop_exp = '{2, 5, 7, 12, 2, 5, 7, 12};

        vecs[0]  = '{1'b1, 1'b0, 5'd3, 16'h0005, 16'h0009, 4'h3,
                     mk(16'h0000, 4'd0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0)};
        vecs[1]  = '{1'b0, 1'b0, 5'd7, 16'hAAAA, 16'hBBBB, 4'h7,
                     mk(16'h0001, 4'd0, 4'd0, 16'h0005, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd0)};
        vecs[2]  = '{1'b0, 1'b0, 5'd7, 16'hAAAA, 16'hBBBB, 4'h7,
                     mk(16'h0002, 4'd1, 4'd0, 16'h0009, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd1)};
        vecs[3]  = '{1'b1, 1'b0, 5'd7, 16'hAAAA, 16'hBBBB, 4'h7,
                     mk(16'h0004, 4'd0, 4'd1, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2)};
        vecs[4]  = '{1'b1, 1'b0, 5'd7, 16'hAAAA, 16'hBBBB, 4'h7,
                     mk(16'h0000, 4'd0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0)};
        vecs[5]  = '{1'b0, 1'b0, 5'd7, 16'hAAAA, 16'hBBBB, 4'h7, idle_o};
        vecs[6]  = '{1'b1, 1'b0, 5'd0, 16'h1234, 16'h00FF, 4'h2,
                     mk(16'h0000, 4'd0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0)};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 16'h1234, 16'h00FF, 4'h2,
                     mk(16'h0001, 4'd0, 4'd0, 16'h1234, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd0)};
        vecs[8]  = '{1'b0, 1'b0, 5'd0, 16'h1234, 16'h00FF, 4'h2,
                     mk(16'h0002, 4'd1, 4'd0, 16'h00FF, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd1)};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 16'h1234, 16'h00FF, 4'h2,
                     mk(16'h0000, 4'd0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0)};
        vecs[10] = '{1'b0, 1'b0, 5'd0, 16'h1234, 16'h00FF, 4'h2, idle_o};

        rst_n = 1'b0; start = 1'b0; loop = 1'b0; step = 1'b1;
        length = 5'd0; seed0 = 16'h0; seed1 = 16'h0; opcode = 4'd0;
        tick(); tick();
        check("reset_outputs", 64'(sample_out()), 64'(idle_o));
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", 64'(sample_out()), 64'(idle_o));

        // Cycle-by-cycle vector table: length 3 run, then length 0 clamped to 2.
        for (int i = 0; i < 11; i++) begin
            start = vecs[i].start; loop = vecs[i].loop; length = vecs[i].len;
            seed0 = vecs[i].s0; seed1 = vecs[i].s1; opcode = vecs[i].op;
            tick();
            check($sformatf("vec%0d", i), 64'(sample_out()), 64'(vecs[i].exp));
        end

        // Fibonacci, length 8.
        base = wr_cnt;
        run_until_done(5'd8, 16'd1, 16'd1, 1'b0, n);
        check("fib8_done_cycle", 64'(n), 64'd9);
        check("fib8_write_count", 64'(wr_cnt - base), 64'd8);
        for (int k = 0; k < 8; k++)
            check($sformatf("fib8_result%0d", k), 64'(wr_val[base + k]), 64'(fib[k]));
        check("fib8_upper_regs_zero",
              64'(regs[8] | regs[9] | regs[10] | regs[11] | regs[12] | regs[13] | regs[14] | regs[15]),
              64'd0);
        tick();
        check("fib8_back_to_idle", 64'(sample_out()), 64'(idle_o));

        // Minimum length: only the two seeds.
        base = wr_cnt;
        run_until_done(5'd2, 16'd3, 16'd4, 1'b0, n);
        check("len2_done_cycle", 64'(n), 64'd3);
        check("len2_write_count", 64'(wr_cnt - base), 64'd2);
        check("len2_r0", 64'(regs[0]), 64'd3);
        check("len2_r1", 64'(regs[1]), 64'd4);
        check("len2_r2_cleared", 64'(regs[2]), 64'd0);
        tick();

        // Over-long request clamps to the full register file.
        base = wr_cnt;
        run_until_done(5'd31, 16'd1, 16'd1, 1'b0, n);
        check("len31_done_cycle", 64'(n), 64'd17);
        check("len31_write_count", 64'(wr_cnt - base), 64'd16);
        check("len31_r15", 64'(regs[15]), 64'd987);
        tick();

        // Loop mode: DONE goes straight to CLEAR.
        base = wr_cnt;
        run_until_done(5'd4, 16'd2, 16'd5, 1'b1, n);
        check("loop_first_done_cycle", 64'(n), 64'd5);
        tick();
        check("loop_clear_nreset", 64'(o_dpn), 64'd0);
        check("loop_clear_busy", 64'(o_busy), 64'd1);
        loop = 1'b0;
        n = 0;
        while (!o_done && n < 64) begin
            tick();
            n++;
        end
        check("loop_second_done_cycle", 64'(n), 64'd5);
        check("loop_write_count", 64'(wr_cnt - base), 64'd8);
        for (int k = 0; k < 8; k++)
            check($sformatf("loop_result%0d", k), 64'(wr_val[base + k]), 64'(loop_exp[k]));
        tick();
        check("loop_exit_idle", 64'(sample_out()), 64'(idle_o));

        // Asynchronous reset during RECUR step 5.
        length = 5'd8; seed0 = 16'd1; seed1 = 16'd1; opcode = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (o_busy && o_we != 16'h0 && o_st == 4'd5) found = 1'b1;
        end
        check("reset_reached_step5", 64'(found), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", 64'(sample_out()), 64'(idle_o));
        tick();
        check("midrun_reset_no_done_a", 64'(o_done), 64'd0);
        tick();
        check("midrun_reset_no_done_b", 64'(o_done), 64'd0);
        rst_n = 1'b1;
        tick();
        base = wr_cnt;
        run_until_done(5'd8, 16'd1, 16'd1, 1'b0, n);
        check("after_reset_done_cycle", 64'(n), 64'd9);
        check("after_reset_r4", 64'(regs[4]), 64'd5);
        check("after_reset_r7", 64'(regs[7]), 64'd21);
        tick();

`ifdef DATAPATH_SEQ_STEP_EN
        // Single-step: one write per I_STEP pulse.
        base = wr_cnt;
        step = 1'b0;
        length = 5'd4; seed0 = 16'd1; seed1 = 16'd2; opcode = 4'd1; loop = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int p = 0; p < 4; p++) begin
            tick();
            tick();
            check($sformatf("step_no_write_%0d", p), 64'(wr_cnt - base), 64'(p));
            step = 1'b1;
            tick();
            step = 1'b0;
            check($sformatf("step_write_%0d", p), 64'(wr_cnt - base), 64'(p + 1));
        end
        check("step_done_after_4th", 64'(o_done), 64'd1);
        check("step_r2", 64'(regs[2]), 64'd3);
        check("step_r3", 64'(regs[3]), 64'd5);
        step = 1'b1;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
